// File: rtl/bit_period_counter_if.sv
// Bit-timer control and status bundle: the master drives enable/clear and
// observes the strobes, bit position and phase returned by the timer.
interface bit_period_counter_if #(
  parameter int ACC_W = 5
);
  logic             enable;
  logic             clear;
  logic             bit_strobe;
  logic [2:0]       bit_index;
  logic             byte_strobe;
  logic [ACC_W-1:0] phase;

  modport master (
    output enable,
    output clear,
    input  bit_strobe,
    input  bit_index,
    input  byte_strobe,
    input  phase
  );

  modport slave (
    input  enable,
    input  clear,
    output bit_strobe,
    output bit_index,
    output byte_strobe,
    output phase
  );
endinterface

// File: rtl/bit_period_counter.sv
// Fractional bit-period timer: a phase accumulator adds INC per enabled clock and wraps at MOD,
// giving a registered one-cycle bit strobe (1 cycle after the wrap edge) plus byte-boundary strobe.
module bit_period_counter #(
  parameter int INC   = 3,
  parameter int MOD   = 25,
  parameter int ACC_W = $clog2(MOD + INC)
) (
  input  logic               clk,
  input  logic               n_rst,
  bit_period_counter_if.slave bus
);

  localparam logic [ACC_W-1:0] C_INC = ACC_W'(INC);
  localparam logic [ACC_W-1:0] C_MOD = ACC_W'(MOD);

  logic [ACC_W-1:0] r_phase;
  logic [2:0]       r_bit_index;
  logic             r_bit_strobe;
  logic             r_byte_strobe;

  logic [ACC_W-1:0] w_sum;
  logic             w_wrap;

  // ACC_W is sized to hold MOD+INC-1, so this sum cannot overflow.
  assign w_sum  = r_phase + C_INC;
  assign w_wrap = (w_sum >= C_MOD);

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      r_phase       <= '0;
      r_bit_index   <= 3'd0;
      r_bit_strobe  <= 1'b0;
      r_byte_strobe <= 1'b0;
    end else if (bus.clear) begin
      r_phase       <= '0;
      r_bit_index   <= 3'd0;
      r_bit_strobe  <= 1'b0;
      r_byte_strobe <= 1'b0;
    end else if (bus.enable) begin
      r_bit_strobe  <= w_wrap;
      r_byte_strobe <= w_wrap && (r_bit_index == 3'd7);
      if (w_wrap) begin
        r_phase     <= w_sum - C_MOD;
        r_bit_index <= r_bit_index + 3'd1;
      end else begin
        r_phase     <= w_sum;
      end
    end else begin
      // Paused: phase and bit position hold so no fractional credit is lost.
      r_bit_strobe  <= 1'b0;
      r_byte_strobe <= 1'b0;
    end
  end

  assign bus.phase       = r_phase;
  assign bus.bit_index   = r_bit_index;
  assign bus.bit_strobe  = r_bit_strobe;
  assign bus.byte_strobe = r_byte_strobe;

endmodule

// File: tb/tb_bit_period_counter.sv
// Directed self-checking bench for bit_period_counter: default 3/25 timer plus a 1/4 override.
module tb_bit_period_counter;

  logic clk;
  logic n_rst;

  bit_period_counter_if #(.ACC_W(5)) bus ();
  bit_period_counter_if #(.ACC_W(3)) sbus ();

  bit_period_counter #(.INC(3), .MOD(25), .ACC_W(5)) dut (
    .clk   (clk),
    .n_rst (n_rst),
    .bus   (bus)
  );

  bit_period_counter #(.INC(1), .MOD(4), .ACC_W(3)) dut_small (
    .clk   (clk),
    .n_rst (n_rst),
    .bus   (sbus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  typedef struct {
    logic       en;
    logic       clr;
    logic       exp_stb;
    logic       exp_byte;
    logic [2:0] exp_idx;
    logic [4:0] exp_ph;
  } vec_t;

  vec_t tbl[19];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Inputs change on the falling edge; outputs are read at the next falling edge.
  task automatic step(input logic en, input logic clr);
    bus.enable = en;
    bus.clear  = clr;
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic sstep(input logic en, input logic clr);
    sbus.enable = en;
    sbus.clear  = clr;
    @(posedge clk);
    @(negedge clk);
  endtask

  function automatic bit is_wrap_edge(input int e);
    int edges[9] = '{9, 17, 25, 34, 42, 50, 59, 67, 75};
    foreach (edges[k]) if (edges[k] == e) return 1'b1;
    return 1'b0;
  endfunction

  initial begin
    int n_stb;
    int n_byte;

    tbl[0]  = '{1'b1, 1'b1, 1'b0, 1'b0, 3'd0, 5'd0};
    tbl[1]  = '{1'b1, 1'b0, 1'b0, 1'b0, 3'd0, 5'd3};
    tbl[2]  = '{1'b0, 1'b0, 1'b0, 1'b0, 3'd0, 5'd3};
    tbl[3]  = '{1'b1, 1'b0, 1'b0, 1'b0, 3'd0, 5'd6};
    tbl[4]  = '{1'b0, 1'b0, 1'b0, 1'b0, 3'd0, 5'd6};
    tbl[5]  = '{1'b1, 1'b0, 1'b0, 1'b0, 3'd0, 5'd9};
    tbl[6]  = '{1'b0, 1'b0, 1'b0, 1'b0, 3'd0, 5'd9};
    tbl[7]  = '{1'b1, 1'b0, 1'b0, 1'b0, 3'd0, 5'd12};
    tbl[8]  = '{1'b0, 1'b0, 1'b0, 1'b0, 3'd0, 5'd12};
    tbl[9]  = '{1'b1, 1'b0, 1'b0, 1'b0, 3'd0, 5'd15};
    tbl[10] = '{1'b0, 1'b0, 1'b0, 1'b0, 3'd0, 5'd15};
    tbl[11] = '{1'b1, 1'b0, 1'b0, 1'b0, 3'd0, 5'd18};
    tbl[12] = '{1'b0, 1'b0, 1'b0, 1'b0, 3'd0, 5'd18};
    tbl[13] = '{1'b1, 1'b0, 1'b0, 1'b0, 3'd0, 5'd21};
    tbl[14] = '{1'b0, 1'b0, 1'b0, 1'b0, 3'd0, 5'd21};
    tbl[15] = '{1'b1, 1'b0, 1'b0, 1'b0, 3'd0, 5'd24};
    tbl[16] = '{1'b0, 1'b0, 1'b0, 1'b0, 3'd0, 5'd24};
    tbl[17] = '{1'b1, 1'b0, 1'b1, 1'b0, 3'd1, 5'd2};
    tbl[18] = '{1'b0, 1'b0, 1'b0, 1'b0, 3'd1, 5'd2};

    bus.enable  = 1'b0;
    bus.clear   = 1'b0;
    sbus.enable = 1'b0;
    sbus.clear  = 1'b0;
    n_rst       = 1'b0;

    // Reset held for two edges, then released with idle inputs.
    @(negedge clk);
    @(negedge clk);
    chk("rst_hold_phase", 32'(bus.phase), 0);
    chk("rst_hold_strobe", 32'(bus.bit_strobe), 0);
    n_rst = 1'b1;
    step(1'b0, 1'b0);
    step(1'b0, 1'b0);
    chk("rst_phase", 32'(bus.phase), 0);
    chk("rst_index", 32'(bus.bit_index), 0);
    chk("rst_bit_strobe", 32'(bus.bit_strobe), 0);
    chk("rst_byte_strobe", 32'(bus.byte_strobe), 0);

    // Asynchronous reset asserted between clock edges while a strobe is high.
    for (int e = 1; e <= 9; e++) step(1'b1, 1'b0);
    chk("pre_arst_strobe", 32'(bus.bit_strobe), 1);
    chk("pre_arst_phase", 32'(bus.phase), 2);
    #2;
    n_rst = 1'b0;
    #1;
    chk("arst_phase", 32'(bus.phase), 0);
    chk("arst_index", 32'(bus.bit_index), 0);
    chk("arst_strobe", 32'(bus.bit_strobe), 0);
    @(negedge clk);
    n_rst = 1'b1;

    // Continuous enable from reset: 9,8,8 periods, no drift.
    n_stb = 0;
    for (int e = 1; e <= 75; e++) begin
      step(1'b1, 1'b0);
      if (is_wrap_edge(e)) n_stb++;
      chk($sformatf("run75_strobe_e%0d", e), 32'(bus.bit_strobe), 32'(is_wrap_edge(e)));
      chk($sformatf("run75_byte_e%0d", e), 32'(bus.byte_strobe), (e == 67) ? 1 : 0);
      chk($sformatf("run75_index_e%0d", e), 32'(bus.bit_index), n_stb % 8);
      if (e == 9)  chk("run75_phase_e9", 32'(bus.phase), 2);
      if (e == 17) chk("run75_phase_e17", 32'(bus.phase), 1);
      if (e == 25 || e == 50 || e == 75)
        chk($sformatf("run75_phase_e%0d", e), 32'(bus.phase), 0);
    end

    // Clear, then alternate enable: disabled cycles only stretch the period.
    for (int i = 0; i < 19; i++) begin
      step(tbl[i].en, tbl[i].clr);
      chk($sformatf("tbl%0d_strobe", i), 32'(bus.bit_strobe), 32'(tbl[i].exp_stb));
      chk($sformatf("tbl%0d_byte", i), 32'(bus.byte_strobe), 32'(tbl[i].exp_byte));
      chk($sformatf("tbl%0d_index", i), 32'(bus.bit_index), 32'(tbl[i].exp_idx));
      chk($sformatf("tbl%0d_phase", i), 32'(bus.phase), 32'(tbl[i].exp_ph));
    end

    // Reach phase=20, bit_index=5 (115 enabled edges), then clear with enable high.
    step(1'b0, 1'b1);
    for (int e = 1; e <= 115; e++) step(1'b1, 1'b0);
    chk("preclr_phase", 32'(bus.phase), 20);
    chk("preclr_index", 32'(bus.bit_index), 5);
    step(1'b1, 1'b1);
    chk("clr_phase", 32'(bus.phase), 0);
    chk("clr_index", 32'(bus.bit_index), 0);
    chk("clr_strobe", 32'(bus.bit_strobe), 0);
    n_stb = 0;
    for (int e = 1; e <= 8; e++) begin
      step(1'b1, 1'b0);
      if (bus.bit_strobe) n_stb++;
    end
    chk("postclr_no_early_strobe", 32'(n_stb), 0);
    step(1'b1, 1'b0);
    chk("postclr_strobe_e9", 32'(bus.bit_strobe), 1);
    chk("postclr_index_e9", 32'(bus.bit_index), 1);
    chk("postclr_phase_e9", 32'(bus.phase), 2);

    // 200 enabled clocks: 24 bit strobes, 3 byte strobes on the 7->0 wraps.
    step(1'b0, 1'b1);
    n_stb  = 0;
    n_byte = 0;
    for (int e = 1; e <= 200; e++) begin
      step(1'b1, 1'b0);
      if (bus.bit_strobe) n_stb++;
      if (bus.byte_strobe) begin
        n_byte++;
        chk($sformatf("run200_byte_with_bit_e%0d", e), 32'(bus.bit_strobe), 1);
        chk($sformatf("run200_byte_index_e%0d", e), 32'(bus.bit_index), 0);
      end
    end
    chk("run200_bit_strobes", 32'(n_stb), 24);
    chk("run200_byte_strobes", 32'(n_byte), 3);
    chk("run200_final_phase", 32'(bus.phase), 0);
    bus.enable = 1'b0;

    // INC=1, MOD=4: strobe every 4th enabled edge, byte strobe every 32.
    for (int e = 1; e <= 64; e++) begin
      sstep(1'b1, 1'b0);
      chk($sformatf("small_strobe_e%0d", e), 32'(sbus.bit_strobe), (e % 4 == 0) ? 1 : 0);
      chk($sformatf("small_byte_e%0d", e), 32'(sbus.byte_strobe), (e % 32 == 0) ? 1 : 0);
      chk($sformatf("small_index_e%0d", e), 32'(sbus.bit_index), (e / 4) % 8);
      chk($sformatf("small_phase_e%0d", e), 32'(sbus.phase), e % 4);
    end
    sstep(1'b0, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
